// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset release sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        GAP,
        SWHOLD,
        DONE
    } seq_state_e;

    // Counter must reach both the last gap count and the saturated hold count.
    function automatic int cnt_width(input int release_gap, input int min_hold);
        int top_val;
        top_val = (release_gap > min_hold) ? release_gap : min_hold;
        return $clog2(top_val + 1);
    endfunction

endpackage

// File: rtl/rst_sync_core.sv
// Reset synchronizer: asserts asynchronously with RST, deasserts after NUM_STAGES CLK edges.
module rst_sync_core #(
    parameter int NUM_STAGES = 4
) (
    input  logic CLK,
    input  logic RST,
    output logic sync_q
);

    logic [NUM_STAGES-1:0] stages;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stages <= '0;
        end else begin
            stages <= {stages[NUM_STAGES-2:0], 1'b1};
        end
    end

    assign sync_q = stages[NUM_STAGES-1];

endmodule

// File: rtl/rst_sync_seq.sv
// Multi-channel reset synchronizer that releases SYNC_RST bits in index order
// with a programmable gap, and re-resets dependent channels on soft requests.
module rst_sync_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int NUM_CH      = 3,
    parameter int RELEASE_GAP = 16,
    parameter int MIN_HOLD    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] SW_RST_REQ,
    output logic [NUM_CH-1:0] SYNC_RST,
    output logic              RST_DONE
);

    localparam int CNT_W = cnt_width(RELEASE_GAP, MIN_HOLD);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    logic sync_q;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] sync_rst_q, sync_rst_d;
    logic              done_q, done_d;

    logic [NUM_CH-1:0] sw_hit;
    logic              sw_take;
    logic [IDX_W-1:0]  sw_idx;

    rst_sync_core #(
        .NUM_STAGES(NUM_STAGES)
    ) u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .sync_q(sync_q)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            sync_rst_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sync_rst_q <= sync_rst_d;
            done_q     <= done_d;
        end
    end

    // Only released channels can be re-reset; in SWHOLD that is exactly j < idx.
    always_comb begin
        sw_hit = SW_RST_REQ & sync_rst_q;
        sw_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (sw_hit[i]) begin
                sw_idx = IDX_W'(i);
            end
        end
        sw_take = (|sw_hit) && (state_q != HOLD);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sync_rst_d = sync_rst_q;
        done_d     = done_q;

        case (state_q)
            HOLD: begin
                sync_rst_d = '0;
                done_d     = 1'b0;
                // The edge that first sees sync_q counts as the first gap cycle.
                if (sync_q) begin
                    state_d = GAP;
                    idx_d   = '0;
                    cnt_d   = CNT_W'(1);
                    if (RELEASE_GAP == 1) begin
                        sync_rst_d[0] = 1'b1;
                        cnt_d         = '0;
                        if (NUM_CH == 1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = IDX_W'(1);
                        end
                    end
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    sync_rst_d[idx_q] = 1'b1;
                    cnt_d             = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SWHOLD: begin
                if (cnt_q < HOLD_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((cnt_q >= HOLD_MAX) && (SW_RST_REQ == '0)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end

            DONE: begin
                done_d = 1'b1;
            end

            default: begin
                state_d = HOLD;
            end
        endcase

        // Entry edge counts as the first hold cycle, so exit is possible at e+MIN_HOLD.
        if (sw_take) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (i >= int'(sw_idx)) begin
                    sync_rst_d[i] = 1'b0;
                end
            end
            done_d  = 1'b0;
            idx_d   = sw_idx;
            cnt_d   = CNT_W'(1);
            state_d = SWHOLD;
        end
    end

    assign SYNC_RST = sync_rst_q;
    assign RST_DONE = done_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Directed bench for rst_sync_seq: default 3-channel instance plus a 1-channel, gap-1 corner instance.
module tb_rst_sync_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] sw_rst_req;
    logic [2:0] sync_rst;
    logic       rst_done;
    logic [0:0] sw1;
    logic [0:0] sync1;
    logic       done1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    always #5 CLK = ~CLK;

    rst_sync_seq #(
        .NUM_STAGES (4),
        .NUM_CH     (3),
        .RELEASE_GAP(16),
        .MIN_HOLD   (4)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_RST_REQ(sw_rst_req),
        .SYNC_RST  (sync_rst),
        .RST_DONE  (rst_done)
    );

    rst_sync_seq #(
        .NUM_STAGES (4),
        .NUM_CH     (1),
        .RELEASE_GAP(1),
        .MIN_HOLD   (4)
    ) u_corner (
        .CLK       (CLK),
        .RST       (RST),
        .SW_RST_REQ(sw1),
        .SYNC_RST  (sync1),
        .RST_DONE  (done1)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic to_edge(input int k);
        while (edge_n < k) begin
            @(posedge CLK);
            edge_n++;
        end
        #1;
    endtask

    task automatic expect_main(input string tag, input logic [2:0] rst_exp, input logic done_exp);
        check({tag, "_rst"}, sync_rst, rst_exp);
        check({tag, "_done"}, {2'b00, rst_done}, {2'b00, done_exp});
    endtask

    initial begin
        RST        = 1'b0;
        sw_rst_req = 3'b000;
        sw1        = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        expect_main("reset", 3'b000, 1'b0);
        check("reset_corner", {2'b00, sync1}, 3'b000);

        // Power-on release sequence
        @(negedge CLK);
        RST    = 1'b1;
        edge_n = 0;
        to_edge(4);
        check("corner_e4", {2'b00, sync1}, 3'b000);
        to_edge(5);
        check("corner_e5", {2'b00, sync1}, 3'b001);
        check("corner_done_e5", {2'b00, done1}, 3'b001);
        to_edge(19);  expect_main("por_e19", 3'b000, 1'b0);
        to_edge(20);  expect_main("por_e20", 3'b001, 1'b0);
        to_edge(35);  expect_main("por_e35", 3'b001, 1'b0);
        to_edge(36);  expect_main("por_e36", 3'b011, 1'b0);
        to_edge(51);  expect_main("por_e51", 3'b011, 1'b0);
        to_edge(52);  expect_main("por_e52", 3'b111, 1'b1);

        // Soft reset of ch1 held two edges (e = 53)
        sw_rst_req = 3'b010;
        to_edge(53);  expect_main("sw010_e", 3'b001, 1'b0);
        to_edge(54);  expect_main("sw010_e1", 3'b001, 1'b0);
        sw_rst_req = 3'b000;
        to_edge(72);  expect_main("sw010_e19", 3'b001, 1'b0);
        to_edge(73);  expect_main("sw010_e20", 3'b011, 1'b0);
        to_edge(88);  expect_main("sw010_e35", 3'b011, 1'b0);
        to_edge(89);  expect_main("sw010_e36", 3'b111, 1'b1);

        // Simultaneous requests 101: lowest wins (e = 90)
        sw_rst_req = 3'b101;
        to_edge(90);  expect_main("sw101_e", 3'b000, 1'b0);
        sw_rst_req = 3'b000;
        to_edge(109); expect_main("sw101_e19", 3'b000, 1'b0);
        to_edge(110); expect_main("sw101_e20", 3'b001, 1'b0);

        // Request for an unreleased channel is ignored
        to_edge(114);
        sw_rst_req = 3'b100;
        to_edge(115); expect_main("ign100", 3'b001, 1'b0);
        sw_rst_req = 3'b000;
        to_edge(125); expect_main("ign100_e125", 3'b001, 1'b0);
        to_edge(126); expect_main("sw101_e36", 3'b011, 1'b0);
        to_edge(141); expect_main("sw101_e51", 3'b011, 1'b0);
        to_edge(142); expect_main("sw101_e52", 3'b111, 1'b1);

        // Request held 10 edges: exit on the edge it drops (155), ch0 at 171
        to_edge(144);
        sw_rst_req = 3'b001;
        to_edge(145); expect_main("hold10_e", 3'b000, 1'b0);
        to_edge(154);
        sw_rst_req = 3'b000;
        to_edge(165); expect_main("hold10_e165", 3'b000, 1'b0);
        to_edge(170); expect_main("hold10_e170", 3'b000, 1'b0);
        to_edge(171); expect_main("hold10_e171", 3'b001, 1'b0);

        // Request 001 while in GAP with idx = 1
        to_edge(174);
        sw_rst_req = 3'b001;
        to_edge(175); expect_main("gap1_e", 3'b000, 1'b0);
        sw_rst_req = 3'b000;
        to_edge(194); expect_main("gap1_e19", 3'b000, 1'b0);
        to_edge(195); expect_main("gap1_e20", 3'b001, 1'b0);

        // Asynchronous RST mid-GAP overrides immediately
        to_edge(200);
        RST = 1'b0;
        #1;
        expect_main("rst_async", 3'b000, 1'b0);
        check("rst_async_corner", {2'b00, sync1}, 3'b000);
        check("rst_async_corner_done", {2'b00, done1}, 3'b000);
        @(negedge CLK);
        RST    = 1'b1;
        edge_n = 0;
        to_edge(5);   check("re_corner_e5", {2'b00, sync1}, 3'b001);
        to_edge(19);  expect_main("re_e19", 3'b000, 1'b0);
        to_edge(20);  expect_main("re_e20", 3'b001, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
